// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared data-memory window; range-checks, applies wait states, acks once.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port 0 always wins ties (no round-robin pointer).
module dmem_arbiter #(
  parameter logic [31:0] BASE        = 32'h24A,
  parameter logic [31:0] LIMIT       = 32'h1249,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        port_l, we_l, err_q;
  logic [31:0] addr_l, wdata_l, rdata_q;
  logic        pick, any_req, in_range;
  logic [31:0] sel_addr;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb pick = ~req0;
`else
  logic last;  // port granted most recently; the other one wins a tie
  always_comb pick = (req0 && req1) ? ~last : req1;
`endif

  always_comb begin
    any_req  = req0 | req1;
    sel_addr = pick ? addr1 : addr0;
    in_range = (sel_addr >= BASE) && (sel_addr <= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata     = '0;
    err       = 1'b0;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE:
        if (any_req) state_nx = in_range ? ACCESS : RESP;
      ACCESS: begin
        mem_cs    = 1'b1;
        mem_addr  = addr_l - BASE;
        mem_wdata = wdata_l;
        if (cnt == 4'd0) begin
          mem_we   = we_l;
          state_nx = RESP;
        end
      end
      RESP: begin
        ack0     = ~port_l;
        ack1     = port_l;
        rdata    = rdata_q;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      port_l  <= 1'b0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE:
          if (any_req) begin
            port_l  <= pick;
            we_l    <= pick ? we1 : we0;
            addr_l  <= sel_addr;
            wdata_l <= pick ? wdata1 : wdata0;
            rdata_q <= '0;
            err_q   <= ~in_range;
            cnt     <= 4'(WAIT_CYCLES);
          end
        ACCESS:
          if (cnt == 4'd0) rdata_q <= we_l ? '0 : mem_rdata;
          else             cnt     <= cnt - 4'd1;
        RESP: begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last <= port_l;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
